// File: rtl/multi_timer.sv
// Multi-channel down-counting timer: one-shot/auto-reload, retrigger, abort, sticky status, count readback.
// Latency: timeout registered L cycles after start; cnt_out one cycle behind cnt_sel/count. No backpressure.
// Optional freeze input enabled by MULTI_TIMER_PAUSE_EN.
module multi_timer #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       stop,
    input  logic [NCH-1:0]       periodic,
    input  logic [NCH*WIDTH-1:0] load_value,
    input  logic [NCH-1:0]       status_clr,
    input  logic [SELW-1:0]      cnt_sel,
`ifdef MULTI_TIMER_PAUSE_EN
    input  logic [NCH-1:0]       pause,
`endif
    output logic [NCH-1:0]       timeout,
    output logic [NCH-1:0]       running,
    output logic [NCH-1:0]       status,
    output logic [WIDTH-1:0]     cnt_out
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic [NCH-1:0]   state_q, state_d;
    logic [NCH-1:0]   mode_q, mode_d;
    logic [NCH-1:0]   timeout_q, timeout_d;
    logic [NCH-1:0]   status_q, status_d;
    logic [WIDTH-1:0] count_q [NCH];
    logic [WIDTH-1:0] count_d [NCH];
    logic [WIDTH-1:0] reload_q [NCH];
    logic [WIDTH-1:0] reload_d [NCH];
    logic [WIDTH-1:0] cnt_out_q, cnt_out_d;
    logic [WIDTH-1:0] lval;
    logic [NCH-1:0]   pause_w;

`ifdef MULTI_TIMER_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = '0;
`endif

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        timeout_d = '0;
        lval      = '0;
        for (int i = 0; i < NCH; i++) begin
            count_d[i]  = count_q[i];
            reload_d[i] = reload_q[i];
            lval = load_value[i*WIDTH +: WIDTH];
            // A zero load behaves as a one-cycle timer rather than wrapping.
            if (lval == '0) lval = WIDTH'(1);
            if (stop[i]) begin
                state_d[i] = ST_IDLE;
                count_d[i] = '0;
            end else if (start[i]) begin
                state_d[i]  = ST_RUN;
                count_d[i]  = lval;
                reload_d[i] = lval;
                mode_d[i]   = periodic[i];
            end else if (state_q[i] == ST_RUN && !pause_w[i]) begin
                if (count_q[i] == WIDTH'(1)) begin
                    timeout_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        count_d[i] = reload_q[i];
                    end else begin
                        state_d[i] = ST_IDLE;
                        count_d[i] = '0;
                    end
                end else begin
                    count_d[i] = count_q[i] - WIDTH'(1);
                end
            end
        end
        // Sticky flag follows the visible pulse; a set beats a clear in the same cycle.
        status_d  = (status_q & ~status_clr) | timeout_q;
        cnt_out_d = '0;
        if (int'(cnt_sel) < NCH) cnt_out_d = count_q[cnt_sel];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= '0;
            mode_q    <= '0;
            timeout_q <= '0;
            status_q  <= '0;
            cnt_out_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                count_q[i]  <= '0;
                reload_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            timeout_q <= timeout_d;
            status_q  <= status_d;
            cnt_out_q <= cnt_out_d;
            for (int i = 0; i < NCH; i++) begin
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
            end
        end
    end

    assign timeout = timeout_q;
    assign running = state_q;
    assign status  = status_q;
    assign cnt_out = cnt_out_q;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: NCH=4/WIDTH=8 main instance plus an NCH=3 instance for out-of-range readback.
module tb_multi_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  start, stop, periodic, status_clr, pause;
    logic [31:0] load_value;
    logic [1:0]  cnt_sel;
    logic [3:0]  timeout, running, status;
    logic [7:0]  cnt_out;

    logic [2:0]  start_b, stop_b, periodic_b, status_clr_b, pause_b;
    logic [23:0] load_value_b;
    logic [1:0]  cnt_sel_b;
    logic [2:0]  timeout_b, running_b, status_b;
    logic [7:0]  cnt_out_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_timer #(.WIDTH(8), .NCH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .periodic(periodic),
        .load_value(load_value), .status_clr(status_clr), .cnt_sel(cnt_sel),
`ifdef MULTI_TIMER_PAUSE_EN
        .pause(pause),
`endif
        .timeout(timeout), .running(running), .status(status), .cnt_out(cnt_out)
    );

    multi_timer #(.WIDTH(8), .NCH(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .periodic(periodic_b),
        .load_value(load_value_b), .status_clr(status_clr_b), .cnt_sel(cnt_sel_b),
`ifdef MULTI_TIMER_PAUSE_EN
        .pause(pause_b),
`endif
        .timeout(timeout_b), .running(running_b), .status(status_b), .cnt_out(cnt_out_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = '0; stop = '0; periodic = '0; status_clr = '0; pause = '0;
        load_value = '0; cnt_sel = '0;
        start_b = '0; stop_b = '0; periodic_b = '0; status_clr_b = '0; pause_b = '0;
        load_value_b = '0; cnt_sel_b = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_timeout", {28'd0, timeout}, 32'd0);
        chk("rst_running", {28'd0, running}, 32'd0);
        chk("rst_status", {28'd0, status}, 32'd0);
        chk("rst_cnt_out", {24'd0, cnt_out}, 32'd0);

        // ch0 one-shot L=5
        load_value[7:0] = 8'd5; start = 4'b0001;
        tick();
        start = '0;
        chk("os_run_start", {31'd0, running[0]}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("os_no_pulse", {31'd0, timeout[0]}, 32'd0);
            chk("os_running", {31'd0, running[0]}, 32'd1);
        end
        tick();
        chk("os_pulse", {31'd0, timeout[0]}, 32'd1);
        chk("os_run_fall", {31'd0, running[0]}, 32'd0);
        tick();
        chk("os_pulse_end", {31'd0, timeout[0]}, 32'd0);
        chk("os_status_set", {31'd0, status[0]}, 32'd1);
        tick();
        chk("os_status_hold", {31'd0, status[0]}, 32'd1);
        status_clr = 4'b0001;
        tick();
        status_clr = '0;
        chk("os_status_clr", {31'd0, status[0]}, 32'd0);

        // ch1 periodic L=3 with readback of ch1
        load_value[15:8] = 8'd3; periodic = 4'b0010; start = 4'b0010; cnt_sel = 2'd1;
        tick();
        start = '0; periodic = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("per_pulse", {31'd0, timeout[1]}, (k % 3 == 0) ? 32'd1 : 32'd0);
            chk("per_running", {31'd0, running[1]}, 32'd1);
            chk("per_cnt_out", {24'd0, cnt_out}, 32'(3 - ((k - 1) % 3)));
        end
        stop = 4'b0010;
        tick();
        stop = '0;
        chk("per_stop_run", {31'd0, running[1]}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("per_stop_quiet", {31'd0, timeout[1]}, 32'd0);
        end

        // ch2 L=10, retrigger with L=4 on the third edge
        load_value[23:16] = 8'd10; start = 4'b0100;
        tick();
        start = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) begin
                load_value[23:16] = 8'd4; start = 4'b0100;
            end
            tick();
            start = '0;
            chk("retrig_pulse", {31'd0, timeout[2]}, (k == 7) ? 32'd1 : 32'd0);
            chk("retrig_run", {31'd0, running[2]}, (k < 7) ? 32'd1 : 32'd0);
        end

        // ch2 load_value 0 behaves as 1
        load_value[23:16] = 8'd0; start = 4'b0100;
        tick();
        start = '0;
        chk("zero_run", {31'd0, running[2]}, 32'd1);
        chk("zero_no_pulse", {31'd0, timeout[2]}, 32'd0);
        tick();
        chk("zero_pulse", {31'd0, timeout[2]}, 32'd1);
        chk("zero_run_fall", {31'd0, running[2]}, 32'd0);

        // ch3 stop on the expiry edge
        load_value[31:24] = 8'd3; start = 4'b1000;
        tick();
        start = '0;
        tick(); tick();
        stop = 4'b1000;
        tick();
        stop = '0;
        chk("stop_exp_pulse", {31'd0, timeout[3]}, 32'd0);
        chk("stop_exp_run", {31'd0, running[3]}, 32'd0);
        tick();
        chk("stop_exp_late", {31'd0, timeout[3]}, 32'd0);

        // clear all sticky flags, then clear coinciding with a pulse
        status_clr = 4'b1111;
        tick();
        status_clr = '0;
        chk("status_all_clr", {28'd0, status}, 32'd0);
        load_value[7:0] = 8'd2; start = 4'b0001;
        tick();
        start = '0;
        tick(); tick();
        chk("clr_race_pulse", {31'd0, timeout[0]}, 32'd1);
        status_clr = 4'b0001;
        tick();
        status_clr = '0;
        chk("clr_race_status", {31'd0, status[0]}, 32'd1);

        // reset while count==2
        load_value[7:0] = 8'd4; start = 4'b0001; cnt_sel = 2'd0;
        tick();
        start = '0;
        tick(); tick();
        chk("pre_rst_cnt", {24'd0, cnt_out}, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_timeout", {28'd0, timeout}, 32'd0);
        chk("mid_rst_running", {28'd0, running}, 32'd0);
        chk("mid_rst_status", {28'd0, status}, 32'd0);
        chk("mid_rst_cnt_out", {24'd0, cnt_out}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_quiet", {28'd0, timeout}, 32'd0);
        end

        // NCH=3 instance: out-of-range selection reads zero
        load_value_b[7:0] = 8'd9; start_b = 3'b001; cnt_sel_b = 2'd3;
        tick();
        start_b = '0;
        chk("oor_cnt_a", {24'd0, cnt_out_b}, 32'd0);
        tick();
        chk("oor_cnt_b", {24'd0, cnt_out_b}, 32'd0);
        cnt_sel_b = 2'd0;
        tick();
        chk("inr_cnt", {24'd0, cnt_out_b}, 32'd8);

`ifdef MULTI_TIMER_PAUSE_EN
        begin
            logic [7:0] exp_cnt [7];
            exp_cnt = '{8'd4, 8'd3, 8'd3, 8'd3, 8'd3, 8'd2, 8'd1};
            load_value[7:0] = 8'd4; start = 4'b0001; cnt_sel = 2'd0;
            tick();
            start = '0;
            for (int k = 1; k <= 8; k++) begin
                pause = (k >= 2 && k <= 4) ? 4'b0001 : 4'b0000;
                tick();
                chk("pause_pulse", {31'd0, timeout[0]}, (k == 7) ? 32'd1 : 32'd0);
                if (k <= 7) chk("pause_cnt", {24'd0, cnt_out}, {24'd0, exp_cnt[k-1]});
            end
            pause = '0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
